// File: rtl/bram_coupler_pkg.sv
// Shared width helpers and the flat data_out lane convention used by
// bram_coupler and by the consumers that unpack its column bus.
package bram_coupler_pkg;

    // Address width for a bank of the given depth; never narrower than 1 bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of a row (bank) index for the given number of rows.
    function automatic int row_idx_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    // Row j occupies data_out[lane_lo(j) +: bus_width].
    function automatic int lane_lo(input int row, input int bus_width);
        return row * bus_width;
    endfunction

endpackage

// File: rtl/bram_coupler_bank.sv
// Simple dual-port block RAM: synchronous write, registered read-first read.
import bram_coupler_pkg::*;

module bram_bank #(
    parameter int BUS_WIDTH = 32,
    parameter int DEPTH     = 1024,
    parameter int AW        = addr_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [BUS_WIDTH-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic [BUS_WIDTH-1:0] rd_data
);

    logic [BUS_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; only the read
    // register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: non-blocking assignments make a same-edge read of the address
    // being written return the old word (read-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/bram_coupler.sv
// Packs a serial word stream into ROWS banks row by row and reads one column
// across all banks per access.
import bram_coupler_pkg::*;

module bram_coupler #(
    parameter int BUS_WIDTH     = 32,
    parameter int ROWS          = 1,
    parameter int MAX_ROW_WIDTH = 1024,
    parameter int AW            = addr_width(MAX_ROW_WIDTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AW:0]               row_width,
    input  logic [BUS_WIDTH-1:0]      data_in,
    input  logic                      wr_en,
    input  logic [AW-1:0]             r_add,
    input  logic                      r_en,
    output logic [ROWS*BUS_WIDTH-1:0] data_out,
    output logic                      valid,
    output logic                      full
);

    localparam int RW = row_idx_width(ROWS);

    logic [AW-1:0] wr_col;
    logic [RW-1:0] wr_row;
    logic          wr_ok;
    logic          rd_ok;
    logic          last_col;
    logic          last_row;

    assign wr_ok    = wr_en && !full;
    assign rd_ok    = r_en && ({1'b0, r_add} < row_width);
    assign last_col = ({1'b0, wr_col} == row_width - (AW + 1)'(1));
    assign last_row = (wr_row == RW'(ROWS - 1));

    // The row pointer saturates on the last row; full blocks further writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_col <= '0;
            wr_row <= '0;
            full   <= 1'b0;
        end else if (wr_ok) begin
            if (last_col) begin
                wr_col <= '0;
                if (last_row) begin
                    full <= 1'b1;
                end else begin
                    wr_row <= wr_row + 1'b1;
                end
            end else begin
                wr_col <= wr_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else begin
            valid <= rd_ok;
        end
    end

    for (genvar j = 0; j < ROWS; j++) begin : g_bank
        localparam int LO = lane_lo(j, BUS_WIDTH);

        bram_bank #(
            .BUS_WIDTH(BUS_WIDTH),
            .DEPTH    (MAX_ROW_WIDTH),
            .AW       (AW)
        ) u_bank (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (wr_ok && (wr_row == RW'(j))),
            .wr_addr(wr_col),
            .wr_data(data_in),
            .rd_en  (rd_ok),
            .rd_addr(r_add),
            .rd_data(data_out[LO +: BUS_WIDTH])
        );
    end

endmodule

// File: tb/tb_bram_coupler.sv
// Directed bench: a single-row instance driven from a vector table and a
// three-row instance driven by a hand-written fill/read sequence.
module tb_bram_coupler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // ROWS=1, row_width=10, default depth.
    logic        rst1 = 1'b0, wr1 = 1'b0, rd1 = 1'b0;
    logic [31:0] wd1 = '0;
    logic [9:0]  ra1 = '0;
    logic [10:0] rw1 = 11'd10;
    logic [31:0] do1;
    logic        v1, f1;

    // ROWS=3, row_width=4, depth 16.
    logic        rst3 = 1'b0, wr3 = 1'b0, rd3 = 1'b0;
    logic [31:0] wd3 = '0;
    logic [3:0]  ra3 = '0;
    logic [4:0]  rw3 = 5'd4;
    logic [95:0] do3;
    logic        v3, f3;

    bram_coupler u_dut1 (
        .clk(clk), .rst(rst1), .row_width(rw1), .data_in(wd1), .wr_en(wr1),
        .r_add(ra1), .r_en(rd1), .data_out(do1), .valid(v1), .full(f1)
    );

    bram_coupler #(.BUS_WIDTH(32), .ROWS(3), .MAX_ROW_WIDTH(16)) u_dut3 (
        .clk(clk), .rst(rst3), .row_width(rw3), .data_in(wd3), .wr_en(wr3),
        .r_add(ra3), .r_en(rd3), .data_out(do3), .valid(v3), .full(f3)
    );

    typedef struct {
        logic        rst;
        logic        wr;
        logic [31:0] wd;
        logic        rd;
        logic [9:0]  ra;
        logic        ev;
        logic        ef;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic wr, input logic [31:0] wd,
                       input logic rd, input logic [9:0] ra,
                       input logic ev, input logic ef, input logic [31:0] ed);
        vec_t v;
        v.rst = rst; v.wr = wr; v.wd = wd; v.rd = rd; v.ra = ra;
        v.ev = ev; v.ef = ef; v.ed = ed;
        vecs.push_back(v);
    endtask

    task automatic step3(input logic rst, input logic wr, input logic [31:0] wd,
                         input logic rd, input logic [3:0] ra);
        @(negedge clk);
        rst3 = rst; wr3 = wr; wd3 = wd; rd3 = rd; ra3 = ra;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, fill 0..9, back-to-back reads, idle hold, range checks.
        add(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 1, i, 0, 0, 0, (i == 9), 0);
        add(0, 0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 0, 1, 1, 1, 1, 1);
        add(0, 0, 0, 1, 2, 1, 1, 2);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 1, 2);
        add(0, 0, 0, 1, 3, 1, 1, 3);
        add(0, 0, 0, 1, 4, 1, 1, 4);
        add(0, 0, 0, 1, 12, 0, 1, 4);
        add(0, 0, 0, 1, 10, 0, 1, 4);
        add(0, 1, 99, 0, 0, 0, 1, 4);
        add(0, 0, 0, 1, 9, 1, 1, 9);
        add(0, 0, 0, 1, 0, 1, 1, 0);
        // Partial fill, reset, refill; column 3 read while being rewritten.
        add(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 100 + i, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 200 + i, 0, 0, 0, 0, 0);
        add(0, 1, 203, 1, 3, 1, 0, 103);
        for (int i = 4; i < 10; i++) add(0, 1, 200 + i, 0, 0, 0, (i == 9), 103);
        add(0, 0, 0, 1, 0, 1, 1, 200);
        add(0, 0, 0, 1, 3, 1, 1, 203);
        add(0, 0, 0, 1, 4, 1, 1, 204);

        foreach (vecs[k]) begin
            @(negedge clk);
            rst1 = vecs[k].rst; wr1 = vecs[k].wr; wd1 = vecs[k].wd;
            rd1 = vecs[k].rd; ra1 = vecs[k].ra;
            @(posedge clk);
            #1;
            check($sformatf("r1_valid[%0d]", k), 128'(v1), 128'(vecs[k].ev));
            check($sformatf("r1_full[%0d]", k), 128'(f1), 128'(vecs[k].ef));
            check($sformatf("r1_data[%0d]", k), 128'(do1), 128'(vecs[k].ed));
        end
        @(negedge clk);
        rst1 = 1'b0; wr1 = 1'b0; rd1 = 1'b0;

        // Three rows of four: fill, overflow write, column reads.
        step3(1, 0, 0, 0, 0);
        check("r3_reset_data", 128'(do3), 128'(0));
        check("r3_reset_valid", 128'(v3), 128'(0));
        check("r3_reset_full", 128'(f3), 128'(0));
        for (int i = 0; i < 12; i++) begin
            step3(0, 1, i, 0, 0);
            check($sformatf("r3_full_w%0d", i), 128'(f3), 128'(i == 11));
        end
        step3(0, 1, 77, 0, 0);
        check("r3_full_overflow", 128'(f3), 128'(1));
        step3(0, 0, 0, 1, 2);
        check("r3_col2_valid", 128'(v3), 128'(1));
        check("r3_col2_data", 128'(do3), 128'({32'd10, 32'd6, 32'd2}));
        step3(0, 0, 0, 1, 5);
        check("r3_oor_valid", 128'(v3), 128'(0));
        check("r3_oor_data", 128'(do3), 128'({32'd10, 32'd6, 32'd2}));
        step3(0, 0, 0, 1, 3);
        check("r3_col3_data", 128'(do3), 128'({32'd11, 32'd7, 32'd3}));
        step3(0, 0, 0, 1, 0);
        check("r3_col0_data", 128'(do3), 128'({32'd8, 32'd4, 32'd0}));
        check("r3_col0_full", 128'(f3), 128'(1));
        step3(0, 0, 0, 0, 0);
        check("r3_idle_valid", 128'(v3), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
